cotm32_csr_trap_unit: RTL and testbench

Machine-mode CSR file and trap sequencer for the cotm32 core; it consumes the Zicsr op/address encodings and trap-cause codes defined in `cotm32_priv_pkg`. It executes CSRRW/RS/RC accesses from the execute stage and latches exception state on traps. It also issues a PC redirect to fetch on trap entry (to `mtvec`) and on `mret` (to `mepc`). It sits between execute/writeback and the fetch PC mux.

---
 rtl/cotm32_priv_pkg.sv | 35 +++
 rtl/cotm32_csr_alu.sv | 23 ++
 rtl/cotm32_csr_trap_unit.sv | 139 +++++++++++++
 tb/tb_cotm32_csr_trap_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cotm32_priv_pkg.sv
// Privileged-architecture types shared by the cotm32 CSR/trap logic:
// Zicsr op and address encodings, trap causes, trap FSM states, mtvec mask.
package cotm32_priv_pkg;

    typedef enum logic [1:0] {
        ZICSR_CSR_OP_NONE = 2'd0,
        ZICSR_CSR_OP_RW   = 2'd1,
        ZICSR_CSR_OP_RS   = 2'd2,
        ZICSR_CSR_OP_RC   = 2'd3
    } zicsr_csr_op_t;

    typedef logic [11:0] zicsr_csr_addr_t;

    localparam zicsr_csr_addr_t ZICSR_CSR_MTVEC    = 12'h305;
    localparam zicsr_csr_addr_t ZICSR_CSR_MSCRATCH = 12'h340;
    localparam zicsr_csr_addr_t ZICSR_CSR_MEPC     = 12'h341;
    localparam zicsr_csr_addr_t ZICSR_CSR_MCAUSE   = 12'h342;
    localparam zicsr_csr_addr_t ZICSR_CSR_MTVAL    = 12'h343;

    // Machine-mode synchronous exception codes fit in four bits.
    localparam int TRAP_CAUSE_W = 4;
    typedef logic [TRAP_CAUSE_W-1:0] trap_cause_t;

    localparam trap_cause_t TRAP_CAUSE_ILLEGAL_INSN = 4'd2;
    localparam trap_cause_t TRAP_CAUSE_BREAKPOINT   = 4'd3;
    localparam trap_cause_t TRAP_CAUSE_ECALL_M      = 4'd11;

    typedef enum logic {
        TRAP_ST_IDLE     = 1'b0,
        TRAP_ST_REDIRECT = 1'b1
    } trap_state_t;

    localparam logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cotm32_csr_alu.sv
// Pure combinational Zicsr new-value function: RW / RS / RC applied to the
// old CSR value and the operand. NONE passes the old value through.
module cotm32_csr_alu
    import cotm32_priv_pkg::*;
(
    input  zicsr_csr_op_t op,
    input  logic [31:0]   old_val,
    input  logic [31:0]   wdata,
    output logic [31:0]   new_val
);

    // Select the new CSR value for the requested operation.
    always_comb begin
        new_val = old_val;
        case (op)
            ZICSR_CSR_OP_RW: new_val = wdata;
            ZICSR_CSR_OP_RS: new_val = old_val | wdata;
            ZICSR_CSR_OP_RC: new_val = old_val & ~wdata;
            default:         new_val = old_val;
        endcase
    end

endmodule

// File: rtl/cotm32_csr_trap_unit.sv
// Machine-mode CSR file (mtvec, mepc, mcause, mtval) and trap sequencer.
// Traps and mret capture a redirect target and hold it on redirect_pc
// until fetch accepts it. Handshake: redirect_valid stays high with a
// stable redirect_pc until a cycle where redirect_ready is also high; the
// transfer happens on that clock edge.
// Optional feature: define COTM32_MSCRATCH_EN to add mscratch (0x340).
module cotm32_csr_trap_unit
    import cotm32_priv_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  zicsr_csr_op_t   csr_op,
    input  zicsr_csr_addr_t csr_addr,
    input  logic [31:0]     csr_wdata,
    output logic [31:0]     csr_rdata,
    output logic            csr_illegal,
    output logic            csr_ready,
    input  logic            trap_valid,
    input  trap_cause_t     trap_cause,
    input  logic [31:0]     trap_pc,
    input  logic [31:0]     trap_tval,
    input  logic            mret_valid,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    input  logic            redirect_ready,
    output logic            busy,
    output trap_state_t     dbg_state
);

    trap_state_t state_q, state_d;
    logic [31:0] mtvec_q, mepc_q, mcause_q, mtval_q, target_q;
`ifdef COTM32_MSCRATCH_EN
    logic [31:0] mscratch_q;
`endif

    logic        csr_active, addr_legal, csr_we, take_trap, take_mret;
    logic [31:0] old_val, new_val;

    // Address decode and pre-write read value.
    always_comb begin
        addr_legal = 1'b0;
        old_val    = 32'h0;
        case (csr_addr)
            ZICSR_CSR_MTVEC:    begin addr_legal = 1'b1; old_val = mtvec_q;    end
            ZICSR_CSR_MEPC:     begin addr_legal = 1'b1; old_val = mepc_q;     end
            ZICSR_CSR_MCAUSE:   begin addr_legal = 1'b1; old_val = mcause_q;   end
            ZICSR_CSR_MTVAL:    begin addr_legal = 1'b1; old_val = mtval_q;    end
`ifdef COTM32_MSCRATCH_EN
            ZICSR_CSR_MSCRATCH: begin addr_legal = 1'b1; old_val = mscratch_q; end
`endif
            default:            begin addr_legal = 1'b0; old_val = 32'h0;      end
        endcase
    end

    assign csr_active  = (csr_op != ZICSR_CSR_OP_NONE);
    assign csr_illegal = csr_active && !addr_legal;
    assign csr_rdata   = (csr_active && addr_legal) ? old_val : 32'h0;

    cotm32_csr_alu u_csr_alu (
        .op      (csr_op),
        .old_val (old_val),
        .wdata   (csr_wdata),
        .new_val (new_val)
    );

    // A trap in the same cycle pre-empts the write; mret does not.
    assign take_trap = (state_q == TRAP_ST_IDLE) && trap_valid;
    assign take_mret = (state_q == TRAP_ST_IDLE) && mret_valid && !trap_valid;
    assign csr_we    = (state_q == TRAP_ST_IDLE) && csr_active && addr_legal && !trap_valid;

    // Next-state logic and handshake outputs of the trap sequencer.
    always_comb begin
        state_d        = state_q;
        redirect_valid = 1'b0;
        busy           = 1'b0;
        csr_ready      = 1'b0;
        case (state_q)
            TRAP_ST_IDLE: begin
                csr_ready = 1'b1;
                if (take_trap || take_mret) state_d = TRAP_ST_REDIRECT;
            end
            TRAP_ST_REDIRECT: begin
                redirect_valid = 1'b1;
                busy           = 1'b1;
                if (redirect_ready) state_d = TRAP_ST_IDLE;
            end
            default: state_d = TRAP_ST_IDLE;
        endcase
    end

    assign redirect_pc = target_q;
    assign dbg_state   = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= TRAP_ST_IDLE;
        else     state_q <= state_d;
    end

    // CSR registers and captured redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec_q  <= RESET_MTVEC & MTVEC_ALIGN_MASK;
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
            mtval_q  <= 32'h0;
            target_q <= 32'h0;
        end else begin
            if (take_trap) begin
                mepc_q   <= trap_pc & MTVEC_ALIGN_MASK;
                mcause_q <= {{(32-TRAP_CAUSE_W){1'b0}}, trap_cause};
                mtval_q  <= trap_tval;
                target_q <= mtvec_q & MTVEC_ALIGN_MASK;
            end else if (take_mret) begin
                target_q <= mepc_q;
            end
            if (csr_we) begin
                case (csr_addr)
                    ZICSR_CSR_MTVEC:  mtvec_q  <= new_val & MTVEC_ALIGN_MASK;
                    ZICSR_CSR_MEPC:   mepc_q   <= new_val & MTVEC_ALIGN_MASK;
                    ZICSR_CSR_MCAUSE: mcause_q <= new_val;
                    ZICSR_CSR_MTVAL:  mtval_q  <= new_val;
                    default:          ;
                endcase
            end
        end
    end

`ifdef COTM32_MSCRATCH_EN
    // Scratch register: full-width, no WARL fields.
    always_ff @(posedge clk) begin
        if (rst)                                             mscratch_q <= 32'h0;
        else if (csr_we && csr_addr == ZICSR_CSR_MSCRATCH) mscratch_q <= new_val;
    end
`endif

endmodule

// File: tb/tb_cotm32_csr_trap_unit.sv
// Bench for cotm32_csr_trap_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the CSR file and redirect handshake.
module tb_cotm32_csr_trap_unit;
    import cotm32_priv_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    zicsr_csr_op_t   csr_op;
    zicsr_csr_addr_t csr_addr;
    logic [31:0]     csr_wdata, csr_rdata;
    logic            csr_illegal, csr_ready;
    logic            trap_valid;
    trap_cause_t     trap_cause;
    logic [31:0]     trap_pc, trap_tval;
    logic            mret_valid, redirect_valid, redirect_ready, busy;
    logic [31:0]     redirect_pc;
    trap_state_t     dbg_state;

    int checks   = 0;
    int failures = 0;

`ifdef COTM32_MSCRATCH_EN
    localparam bit MSCR_ON = 1'b1;
`else
    localparam bit MSCR_ON = 1'b0;
`endif

    // Clock / reset block.
    always #5 clk = ~clk;

    cotm32_csr_trap_unit #(.RESET_MTVEC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .csr_ready(csr_ready), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy), .dbg_state(dbg_state)
    );

    // Behavioural model: architectural CSR values and the pending redirect.
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_target;
    bit          m_redir;
    logic [31:0] exp_rdata, exp_rpc;
    bit          exp_illegal, exp_rv;

    function automatic bit m_legal(input logic [11:0] a);
        return (a == 12'h305) || (a == 12'h341) || (a == 12'h342) ||
               (a == 12'h343) || (MSCR_ON && a == 12'h340);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h340: return m_mscratch;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_mscratch = 0; m_target = 0; m_redir = 0;
    endtask

    // Driver: applies one cycle of inputs at the falling edge, records the
    // model's expectation for this cycle, then advances the model past the
    // coming rising edge. Outputs are sampled 1 time unit later.
    task automatic drive(input bit r, input zicsr_csr_op_t op, input logic [11:0] a,
                         input logic [31:0] wd, input bit tv, input trap_cause_t tc,
                         input logic [31:0] tpc, input logic [31:0] ttv,
                         input bit mr, input bit rr);
        logic [31:0] old, nv, old_mepc;
        @(negedge clk);
        rst = r; csr_op = op; csr_addr = a; csr_wdata = wd; trap_valid = tv;
        trap_cause = tc; trap_pc = tpc; trap_tval = ttv; mret_valid = mr;
        redirect_ready = rr;
        exp_illegal = (op != ZICSR_CSR_OP_NONE) && !m_legal(a);
        exp_rdata   = ((op != ZICSR_CSR_OP_NONE) && m_legal(a)) ? m_read(a) : 32'h0;
        exp_rv      = m_redir;
        exp_rpc     = m_target;
        if (r) begin
            m_reset();
        end else if (m_redir) begin
            if (rr) m_redir = 0;
        end else if (tv) begin
            m_mepc = {tpc[31:2], 2'b00}; m_mcause = {28'h0, tc}; m_mtval = ttv;
            m_target = {m_mtvec[31:2], 2'b00}; m_redir = 1;
        end else begin
            old_mepc = m_mepc;
            if (op != ZICSR_CSR_OP_NONE && m_legal(a)) begin
                old = m_read(a);
                nv  = (op == ZICSR_CSR_OP_RW) ? wd : (op == ZICSR_CSR_OP_RS) ? (old | wd) : (old & ~wd);
                case (a)
                    12'h305: m_mtvec    = {nv[31:2], 2'b00};
                    12'h341: m_mepc     = {nv[31:2], 2'b00};
                    12'h342: m_mcause   = nv;
                    12'h343: m_mtval    = nv;
                    default: m_mscratch = nv;
                endcase
            end
            if (mr) begin m_target = old_mepc; m_redir = 1; end
        end
        #1;
    endtask

    task automatic idle(input bit rr);
        drive(0, ZICSR_CSR_OP_NONE, 12'h0, 0, 0, 4'd0, 0, 0, 0, rr);
    endtask

    // Read via RS with a zero mask: returns the value without changing it.
    task automatic peek(input logic [11:0] a);
        drive(0, ZICSR_CSR_OP_RS, a, 0, 0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic csr(input zicsr_csr_op_t op, input logic [11:0] a, input logic [31:0] wd);
        drive(0, op, a, wd, 0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic trap(input trap_cause_t tc, input logic [31:0] tpc, input logic [31:0] ttv);
        drive(0, ZICSR_CSR_OP_NONE, 12'h0, 0, 1, tc, tpc, ttv, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, ZICSR_CSR_OP_NONE, 12'h0, 0, 0, 4'd0, 0, 0, 0, 0);
        idle(0);
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (csr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", csr_ready); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
        checks++; if (dbg_state !== TRAP_ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); end
        peek(12'h305);
        checks++; if (csr_rdata !== 32'h100) begin failures++; $display("FAIL reset_mtvec got=%h exp=00000100", csr_rdata); end
        peek(12'h341);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL reset_mepc got=%h exp=0", csr_rdata); end
        peek(12'h342);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL reset_mcause got=%h exp=0", csr_rdata); end
        peek(12'h343);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL reset_mtval got=%h exp=0", csr_rdata); end
    endtask

    task automatic test_csr_ops();
        csr(ZICSR_CSR_OP_RW, 12'h305, 32'h8000_0003);
        checks++; if (csr_rdata !== 32'h100) begin failures++; $display("FAIL rw_old got=%h exp=00000100", csr_rdata); end
        checks++; if (csr_illegal !== 1'b0) begin failures++; $display("FAIL rw_illegal got=%b exp=0", csr_illegal); end
        csr(ZICSR_CSR_OP_RS, 12'h305, 32'h10);
        checks++; if (csr_rdata !== 32'h8000_0000) begin failures++; $display("FAIL rs_old got=%h exp=80000000", csr_rdata); end
        csr(ZICSR_CSR_OP_RC, 12'h305, 32'h8000_0000);
        checks++; if (csr_rdata !== 32'h8000_0010) begin failures++; $display("FAIL rc_old got=%h exp=80000010", csr_rdata); end
        peek(12'h305);
        checks++; if (csr_rdata !== 32'h10) begin failures++; $display("FAIL rc_result got=%h exp=00000010", csr_rdata); end
    endtask

    task automatic test_trap();
        csr(ZICSR_CSR_OP_RW, 12'h305, 32'h400);
        trap(4'd2, 32'h2002, 32'hDEAD);
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL trap_rv_early got=%b exp=0", redirect_valid); end
        idle(0);
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL trap_rv got=%b exp=1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h400) begin failures++; $display("FAIL trap_rpc got=%h exp=00000400", redirect_pc); end
        checks++; if (busy !== 1'b1 || csr_ready !== 1'b0) begin failures++; $display("FAIL trap_busy got=%b%b exp=10", busy, csr_ready); end
        checks++; if (dbg_state !== TRAP_ST_REDIRECT) begin failures++; $display("FAIL trap_state got=%0d exp=REDIRECT", dbg_state); end
        peek(12'h341);
        checks++; if (csr_rdata !== 32'h2000) begin failures++; $display("FAIL trap_mepc got=%h exp=00002000", csr_rdata); end
        peek(12'h342);
        checks++; if (csr_rdata !== 32'h2) begin failures++; $display("FAIL trap_mcause got=%h exp=2", csr_rdata); end
        peek(12'h343);
        checks++; if (csr_rdata !== 32'hDEAD) begin failures++; $display("FAIL trap_mtval got=%h exp=0000dead", csr_rdata); end
        for (int i = 0; i < 3; i++) begin
            drive(0, ZICSR_CSR_OP_NONE, 12'h0, 0, (i == 1), 4'd3, 32'h9000, 32'h1, 0, 0);
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin failures++; $display("FAIL hold_%0d got=%b/%h exp=1/00000400", i, redirect_valid, redirect_pc); end
        end
        idle(1);
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL accept_rv got=%b exp=1", redirect_valid); end
        idle(0);
        checks++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL release got=%b%b exp=00", redirect_valid, busy); end
        peek(12'h342);
        checks++; if (csr_rdata !== 32'h2) begin failures++; $display("FAIL ignored_trap_mcause got=%h exp=2", csr_rdata); end
    endtask

    task automatic test_priority();
        drive(0, ZICSR_CSR_OP_RW, 12'h343, 32'h55, 1, 4'd5, 32'h3000, 32'h11, 1, 0);
        checks++; if (csr_rdata !== 32'hDEAD) begin failures++; $display("FAIL prio_rdata got=%h exp=0000dead", csr_rdata); end
        idle(1);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin failures++; $display("FAIL prio_rpc got=%b/%h exp=1/00000400", redirect_valid, redirect_pc); end
        idle(0);
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL prio_dwell got=%b exp=0", redirect_valid); end
        peek(12'h343);
        checks++; if (csr_rdata !== 32'h11) begin failures++; $display("FAIL prio_mtval got=%h exp=00000011", csr_rdata); end
        peek(12'h341);
        checks++; if (csr_rdata !== 32'h3000) begin failures++; $display("FAIL prio_mepc got=%h exp=00003000", csr_rdata); end
    endtask

    task automatic test_mret();
        drive(0, ZICSR_CSR_OP_RW, 12'h341, 32'h5003, 0, 4'd0, 0, 0, 1, 0);
        checks++; if (csr_rdata !== 32'h3000) begin failures++; $display("FAIL mret_rdata got=%h exp=00003000", csr_rdata); end
        idle(1);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000) begin failures++; $display("FAIL mret_rpc got=%b/%h exp=1/00003000", redirect_valid, redirect_pc); end
        idle(0);
        peek(12'h341);
        checks++; if (csr_rdata !== 32'h5000) begin failures++; $display("FAIL mret_mepc got=%h exp=00005000", csr_rdata); end
    endtask

    task automatic test_back_to_back();
        trap(4'd7, 32'h6000, 32'h1);
        idle(1);
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b exp=1", redirect_valid); end
        trap(4'd4, 32'h7004, 32'h2);
        checks++; if (redirect_valid !== 1'b0 || csr_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b%b exp=01", redirect_valid, csr_ready); end
        idle(1);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h400) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/00000400", redirect_valid, redirect_pc); end
        idle(0);
        peek(12'h342);
        checks++; if (csr_rdata !== 32'h4) begin failures++; $display("FAIL b2b_mcause got=%h exp=4", csr_rdata); end
        peek(12'h341);
        checks++; if (csr_rdata !== 32'h7004) begin failures++; $display("FAIL b2b_mepc got=%h exp=00007004", csr_rdata); end
    endtask

    task automatic test_mscratch();
        csr(ZICSR_CSR_OP_RW, 12'h340, 32'h1234);
`ifdef COTM32_MSCRATCH_EN
        checks++; if (csr_illegal !== 1'b0 || csr_rdata !== 32'h0) begin failures++; $display("FAIL mscratch_rw got=%b/%h exp=0/0", csr_illegal, csr_rdata); end
        peek(12'h340);
        checks++; if (csr_rdata !== 32'h1234) begin failures++; $display("FAIL mscratch_rd got=%h exp=00001234", csr_rdata); end
`else
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin failures++; $display("FAIL mscratch_illegal got=%b/%h exp=1/0", csr_illegal, csr_rdata); end
        peek(12'h340);
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin failures++; $display("FAIL mscratch_nowrite got=%b/%h exp=1/0", csr_illegal, csr_rdata); end
`endif
        csr(ZICSR_CSR_OP_RW, 12'h7C0, 32'hFFFF);
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin failures++; $display("FAIL unimpl got=%b/%h exp=1/0", csr_illegal, csr_rdata); end
    endtask

    task automatic test_reset_in_redirect();
        trap(4'd1, 32'h8000, 32'h3);
        idle(0);
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL rstr_pre got=%b exp=1", redirect_valid); end
        drive(1, ZICSR_CSR_OP_NONE, 12'h0, 0, 0, 4'd0, 0, 0, 0, 0);
        idle(0);
        checks++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstr_abort got=%b%b exp=00", redirect_valid, busy); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rstr_rpc got=%h exp=0", redirect_pc); end
        peek(12'h305);
        checks++; if (csr_rdata !== 32'h100) begin failures++; $display("FAIL rstr_mtvec got=%h exp=00000100", csr_rdata); end
        peek(12'h341);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL rstr_mepc got=%h exp=0", csr_rdata); end
        peek(12'h342);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL rstr_mcause got=%h exp=0", csr_rdata); end
        peek(12'h343);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL rstr_mtval got=%h exp=0", csr_rdata); end
    endtask

    task automatic test_random();
        logic [11:0] addrs [5];
        logic [11:0] a;
        addrs = '{12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : addrs[$urandom_range(0, 4)];
            drive(($urandom_range(0, 60) == 0), zicsr_csr_op_t'($urandom_range(0, 3)), a, $urandom(),
                  ($urandom_range(0, 7) == 0), trap_cause_t'($urandom_range(0, 15)), $urandom(), $urandom(),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
            checks++; if (csr_rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, csr_rdata, exp_rdata); end
            checks++; if (csr_illegal !== exp_illegal) begin failures++; $display("FAIL rnd_illegal n=%0d got=%b exp=%b", n, csr_illegal, exp_illegal); end
            checks++; if (redirect_valid !== exp_rv) begin failures++; $display("FAIL rnd_rv n=%0d got=%b exp=%b", n, redirect_valid, exp_rv); end
            checks++; if (redirect_pc !== exp_rpc) begin failures++; $display("FAIL rnd_rpc n=%0d got=%h exp=%h", n, redirect_pc, exp_rpc); end
            checks++; if (busy !== exp_rv || csr_ready !== !exp_rv) begin failures++; $display("FAIL rnd_busy n=%0d got=%b%b exp=%b%b", n, busy, csr_ready, exp_rv, !exp_rv); end
        end
    endtask

    initial begin
        rst = 1'b1; csr_op = ZICSR_CSR_OP_NONE; csr_addr = '0; csr_wdata = '0;
        trap_valid = 0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
        mret_valid = 0; redirect_ready = 0;
        m_reset();
        test_reset();
        test_csr_ops();
        test_mscratch();
        test_trap();
        test_priority();
        test_mret();
        test_back_to_back();
        test_reset_in_redirect();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
